// File: rtl/tmem_pkg.sv
// Shared state encoding and overflow-mode constants for the temporal-memory bank.
package tmem_pkg;

  // Per-channel FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  // Overflow behaviour while counting a write pulse
  localparam int unsigned OVF_WRAP = 0;
  localparam int unsigned OVF_SAT  = 1;

endpackage

// File: rtl/tmem_chan.sv
// One temporal-memory channel: measures a write pulse, holds it, replays it as a delayed fire pulse.
module tmem_chan
  import tmem_pkg::*;
#(
  parameter int unsigned BITS     = 4,
  parameter int unsigned SATURATE = OVF_WRAP
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            we,
  input  logic            re,
  output logic            fire,
  output logic            valid,
  output logic            busy,
  output logic            carry,
  output logic [BITS-1:0] value
);

  localparam logic [BITS-1:0] CNT_MAX = {BITS{1'b1}};

  logic [1:0]      r_state, w_state_nxt;
  logic [BITS-1:0] r_cnt, w_cnt_nxt;
  logic [BITS-1:0] r_value, w_value_nxt;
  logic            r_carry, w_carry_nxt;
  logic            r_fire, w_fire_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_busy, w_busy_nxt;

  // Next-state and next-output decode; a new write pulse overrides everything else
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_value_nxt = r_value;
    w_carry_nxt = r_carry;
    w_fire_nxt  = 1'b0;

    if (we && (r_state != ST_WRITE)) begin
      w_state_nxt = ST_WRITE;
      w_cnt_nxt   = BITS'(1);
      w_carry_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_WRITE: begin
          if (we) begin
            if (r_cnt == CNT_MAX) begin
              w_carry_nxt = 1'b1;
              w_cnt_nxt   = (SATURATE == OVF_SAT) ? CNT_MAX : '0;
            end else begin
              w_cnt_nxt = r_cnt + BITS'(1);
            end
          end else begin
            w_value_nxt = r_cnt;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (re) begin
            w_state_nxt = ST_READ;
            w_cnt_nxt   = r_value;
          end
        end
        ST_READ: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - BITS'(1);
          end else begin
            w_fire_nxt  = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end
        default: begin
        end
      endcase
    end

    w_valid_nxt = (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_READ);
    w_busy_nxt  = (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_READ);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_value <= '0;
      r_carry <= 1'b0;
      r_fire  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_value <= w_value_nxt;
      r_carry <= w_carry_nxt;
      r_fire  <= w_fire_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign fire  = r_fire;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign carry = r_carry;
  assign value = r_value;

endmodule

// File: rtl/tmem_bank.sv
// Bank of independent temporal-memory channels with packed stored-value output.
module tmem_bank
  import tmem_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned BITS     = 4,
  parameter int unsigned SATURATE = OVF_WRAP
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [CHANNELS-1:0]      we,
  input  logic [CHANNELS-1:0]      re,
  output logic [CHANNELS-1:0]      fire,
  output logic [CHANNELS-1:0]      valid,
  output logic [CHANNELS-1:0]      busy,
  output logic [CHANNELS-1:0]      carry,
  output logic [CHANNELS*BITS-1:0] value
);

  // One channel per bit of we/re; value slices packed low channel first
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    tmem_chan #(
      .BITS     (BITS),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk   (clk),
      .rstb  (rstb),
      .we    (we[gi]),
      .re    (re[gi]),
      .fire  (fire[gi]),
      .valid (valid[gi]),
      .busy  (busy[gi]),
      .carry (carry[gi]),
      .value (value[gi*BITS +: BITS])
    );
  end

endmodule
